channel_blocker: RTL and testbench

Downstream stage of the polyphase channelizer. Consumes its round-robin channel stream (one sample per channel per frame, channel 0 flagged by `in_first`) and regroups it into per-channel blocks of BLKLEN consecutive samples using a ping-pong buffer. Blocks are emitted channel by channel over a valid/ready stream for per-channel back-end processing. Misalignment and buffer overflow are reported on a sticky `error`.

---
 rtl/channel_blocker_if.sv | 29 ++
 rtl/channel_blocker.sv | 171 +++++++++++++++++
 tb/tb_channel_blocker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/channel_blocker_if.sv
// Stream bundle for channel_blocker: channelizer input side and block output side.
// The slave modport is the blocker's view; master is the upstream/downstream view.
interface channel_blocker_if #(
    parameter int WDTH  = 32,
    parameter int MWDTH = 1,
    parameter int LOGN  = 3
);
    logic [WDTH-1:0]  in_data;
    logic             in_nd;
    logic [MWDTH-1:0] in_m;
    logic             in_first;
    logic [WDTH-1:0]  out_data;
    logic [MWDTH-1:0] out_m;
    logic [LOGN-1:0]  out_channel;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             error;

    modport master (
        output in_data, in_nd, in_m, in_first, out_ready,
        input  out_data, out_m, out_channel, out_last, out_valid, error
    );

    modport slave (
        input  in_data, in_nd, in_m, in_first, out_ready,
        output out_data, out_m, out_channel, out_last, out_valid, error
    );
endinterface

// File: rtl/channel_blocker.sv
// Regroups a round-robin channel stream into per-channel blocks through a ping-pong RAM.
// Define CHANNEL_BLOCKER_META_EN to store in_m per sample and carry it on out_m.
module channel_blocker #(
    parameter int N      = 8,
    parameter int LOGN   = 3,
    parameter int WDTH   = 32,
    parameter int MWDTH  = 1,
    parameter int BLKLEN = 16,
    parameter int LOGBLK = 4
) (
    input logic clk,
    input logic rst_n,
    channel_blocker_if.slave bus
);
    localparam int AW    = 1 + LOGN + LOGBLK;
    localparam int DEPTH = 1 << AW;
`ifdef CHANNEL_BLOCKER_META_EN
    localparam int SW = WDTH + MWDTH;
`else
    localparam int SW = WDTH;
`endif
    localparam logic WS_SYNC = 1'b0;
    localparam logic WS_RUN  = 1'b1;
    localparam logic RS_IDLE = 1'b0;
    localparam logic RS_READ = 1'b1;

    logic [SW-1:0] mem [DEPTH];

    logic                   wstate_q, wstate_d;
    logic [LOGN-1:0]        wch_q, wch_d;
    logic [LOGBLK-1:0]      ws_q, ws_d;
    logic                   wb_q, wb_d;
    logic                   drop_q, drop_d;
    logic [1:0]             full_q, full_d;
    logic                   err_q, err_d;
    logic                   rstate_q, rstate_d;
    logic [LOGN+LOGBLK-1:0] rcnt_q, rcnt_d;
    logic                   rdone_q, rdone_d;
    logic                   rb_q, rb_d;
    logic                   ov_q, ov_d;
    logic [SW-1:0]          rdata_q;
    logic [LOGN-1:0]        och_q;
    logic                   olast_q;

    logic              pop, fin, issue_ok, re;
    logic [1:0]        clr, set, full_eff;
    logic              act, misalign, restart, blk_start, drop_now, we, blk_end;
    logic [LOGN-1:0]   eff_ch;
    logic [LOGBLK-1:0] eff_s;
    logic [SW-1:0]     wdata;

    // Read side: the RAM read register doubles as the output register, so reads
    // are issued only when that register is empty or being drained this cycle.
    assign pop      = ov_q & bus.out_ready;
    assign fin      = pop & olast_q & (och_q == LOGN'(N - 1));
    assign issue_ok = (rstate_q == RS_READ) ? ~rdone_q : full_q[rb_q];
    assign re       = issue_ok & (~ov_q | bus.out_ready);

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        rdone_d  = rdone_q;
        rb_d     = rb_q;
        clr      = '0;
        ov_d     = re ? 1'b1 : (pop ? 1'b0 : ov_q);
        if (re) begin
            rstate_d = RS_READ;
            rcnt_d   = rcnt_q + 1'b1;
            if (rcnt_q == '1) rdone_d = 1'b1;
        end
        if (fin) begin
            clr[rb_q] = 1'b1;
            rb_d      = ~rb_q;
            rcnt_d    = '0;
            rdone_d   = 1'b0;
            rstate_d  = full_q[~rb_q] ? RS_READ : RS_IDLE;
        end
    end

    // Write side: a misaligned sample restarts the block at ch 0, s 0 of the same bank.
    assign act       = bus.in_nd & ((wstate_q == WS_RUN) | bus.in_first);
    assign misalign  = bus.in_nd & (wstate_q == WS_RUN) & (bus.in_first != (wch_q == '0));
    assign restart   = (wstate_q == WS_SYNC) | misalign;
    assign eff_ch    = restart ? '0 : wch_q;
    assign eff_s     = restart ? '0 : ws_q;
    assign blk_start = (eff_ch == '0) & (eff_s == '0);
    assign full_eff  = full_q & ~clr;
    assign drop_now  = blk_start ? full_eff[wb_q] : drop_q;
    assign we        = act & ~drop_now;
    assign blk_end   = we & (eff_ch == LOGN'(N - 1)) & (eff_s == LOGBLK'(BLKLEN - 1));

    always_comb begin
        wstate_d = wstate_q;
        wch_d    = wch_q;
        ws_d     = ws_q;
        wb_d     = wb_q;
        drop_d   = drop_q;
        err_d    = err_q;
        set      = '0;
        if (act) begin
            wstate_d = WS_RUN;
            wch_d    = eff_ch + 1'b1;
            ws_d     = (eff_ch == LOGN'(N - 1)) ? eff_s + 1'b1 : eff_s;
            drop_d   = drop_now;
            if (misalign | (blk_start & full_eff[wb_q])) err_d = 1'b1;
        end
        if (blk_end) begin
            set[wb_q] = 1'b1;
            wb_d      = ~wb_q;
        end
        full_d = full_eff | set;
    end

`ifdef CHANNEL_BLOCKER_META_EN
    assign wdata     = {bus.in_m, bus.in_data};
    assign bus.out_m = rdata_q[WDTH +: MWDTH];
`else
    logic unused_meta;
    assign unused_meta = ^bus.in_m;
    assign wdata       = bus.in_data;
    assign bus.out_m   = '0;
`endif

    always_ff @(posedge clk) begin
        if (we) mem[{wb_q, eff_ch, eff_s}] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= WS_SYNC;
            wch_q    <= '0;
            ws_q     <= '0;
            wb_q     <= 1'b0;
            drop_q   <= 1'b0;
            full_q   <= '0;
            err_q    <= 1'b0;
            rstate_q <= RS_IDLE;
            rcnt_q   <= '0;
            rdone_q  <= 1'b0;
            rb_q     <= 1'b0;
            ov_q     <= 1'b0;
            rdata_q  <= '0;
            och_q    <= '0;
            olast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wch_q    <= wch_d;
            ws_q     <= ws_d;
            wb_q     <= wb_d;
            drop_q   <= drop_d;
            full_q   <= full_d;
            err_q    <= err_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            rdone_q  <= rdone_d;
            rb_q     <= rb_d;
            ov_q     <= ov_d;
            if (re) begin
                rdata_q <= mem[{rb_q, rcnt_q}];
                och_q   <= rcnt_q[LOGN+LOGBLK-1:LOGBLK];
                olast_q <= (rcnt_q[LOGBLK-1:0] == LOGBLK'(BLKLEN - 1));
            end
        end
    end

    assign bus.out_data    = rdata_q[WDTH-1:0];
    assign bus.out_channel = och_q;
    assign bus.out_last    = olast_q;
    assign bus.out_valid   = ov_q;
    assign bus.error       = err_q;
endmodule

// File: tb/tb_channel_blocker.sv
// Bench for channel_blocker: directed phases with random data/ready, checked against
// a frame/block reference model (bank occupancy counted as completed-but-unread blocks).
module tb_channel_blocker;
    localparam int N      = 8;
    localparam int LOGN   = 3;
    localparam int WDTH   = 32;
    localparam int MWDTH  = 1;
    localparam int BLKLEN = 16;
    localparam int LOGBLK = 4;
    localparam int BLK    = N * BLKLEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    channel_blocker_if #(.WDTH(WDTH), .MWDTH(MWDTH), .LOGN(LOGN)) bus ();

    channel_blocker #(
        .N(N), .LOGN(LOGN), .WDTH(WDTH), .MWDTH(MWDTH), .BLKLEN(BLKLEN), .LOGBLK(LOGBLK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    bit               m_run, m_drop, m_err;
    int               m_pos, m_pending, m_pushed;
    logic [WDTH-1:0]  m_buf  [BLK];
    logic [MWDTH-1:0] m_mbuf [BLK];
    logic [WDTH-1:0]  q_data [$];
    logic [MWDTH-1:0] q_m    [$];
    int               q_k    [$];
    bit               prev_stall;
    int               accepted;
    logic [WDTH-1:0]  first_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_drop = 0; m_err = 0;
        m_pos = 0; m_pending = 0; m_pushed = 0;
        q_data.delete(); q_m.delete(); q_k.delete();
        prev_stall = 0; accepted = 0;
    endtask

    // Position in the frame is pos = s*N + ch; blocks are read out channel-major.
    task automatic model_in(input logic first, input logic [WDTH-1:0] d, input logic [MWDTH-1:0] m);
        int pos;
        if (!m_run) begin
            if (!first) return;
            m_run = 1;
            pos = 0;
        end else begin
            pos = m_pos;
            if (first != (pos % N == 0)) begin
                m_err = 1;
                pos = 0;
            end
        end
        if (pos == 0) begin
            m_drop = (m_pending == 2);
            if (m_drop) m_err = 1;
        end
        if (!m_drop) begin
            m_buf[(pos % N) * BLKLEN + pos / N]  = d;
            m_mbuf[(pos % N) * BLKLEN + pos / N] = m;
        end
        if (pos == BLK - 1 && !m_drop) begin
            for (int k = 0; k < BLK; k++) begin
                q_data.push_back(m_buf[k]);
`ifdef CHANNEL_BLOCKER_META_EN
                q_m.push_back(m_mbuf[k]);
`else
                q_m.push_back('0);
`endif
                q_k.push_back(k);
            end
            m_pending++;
            m_pushed += BLK;
        end
        m_pos = (pos + 1) % BLK;
    endtask

    // One cycle: observe at the negedge, then drive inputs for the next rising edge.
    task automatic step(input logic nd, input logic first, input logic [WDTH-1:0] d, input logic rdy);
        logic [MWDTH-1:0] m;
        m = d[MWDTH-1:0];
        check("error", bus.error, m_err);
        if (prev_stall) check("hold_valid", bus.out_valid, 1'b1);
        if (bus.out_valid) begin
            tests++;
            assert (q_data.size() != 0) else begin
                fails++;
                $error("FAIL spurious_word: observed word %0h expected none", bus.out_data);
            end
            if (q_data.size() != 0) begin
                check("data", bus.out_data, q_data[0]);
                check("meta", bus.out_m, q_m[0]);
                check("channel", bus.out_channel, q_k[0] / BLKLEN);
                check("last", bus.out_last, (q_k[0] % BLKLEN) == BLKLEN - 1);
                if (rdy) begin
                    if (accepted == 0) first_out = bus.out_data;
                    if (q_k[0] == BLK - 1) m_pending--;
                    void'(q_data.pop_front());
                    void'(q_m.pop_front());
                    void'(q_k.pop_front());
                    accepted++;
                end
            end
        end
        bus.in_nd     = nd;
        bus.in_first  = first;
        bus.in_data   = d;
        bus.in_m      = m;
        bus.out_ready = rdy;
        if (nd) model_in(first, d, m);
        prev_stall = bus.out_valid && !rdy;
        @(negedge clk);
    endtask

    task automatic drain(input int maxc, input bit toggle);
        int c = 0;
        while ((q_data.size() != 0 || bus.out_valid) && c < maxc) begin
            step(1'b0, 1'b0, '0, toggle ? (c % 2 == 0) : 1'b1);
            c++;
        end
        check("drain_left", q_data.size(), 0);
        check("word_count", accepted, m_pushed);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_nd = 1'b0; bus.in_first = 1'b0; bus.in_data = '0; bus.in_m = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 0);
        check("rst_meta", bus.out_m, 0);
        check("rst_channel", bus.out_channel, 0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_error", bus.error, 1'b0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        logic [WDTH-1:0] first_in;
        @(negedge clk);
        do_reset();

        // Two aligned frames, index data, ready held high.
        for (int i = 0; i < 2 * BLK; i++) begin
            if (i == BLK) check("latency_t1", bus.out_valid, 1'b0);
            if (i == BLK + 1) begin
                check("latency_t2", bus.out_valid, 1'b1);
                check("first_word", bus.out_data, 0);
            end
            step(1'b1, (i % N) == 0, WDTH'(i), 1'b1);
        end
        drain(600, 1'b0);
        check("frames_256", accepted, 256);

        // Junk before the first channel-0 sample is ignored.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom, 1'b1);
        first_in = $urandom;
        for (int i = 0; i < BLK; i++)
            step(1'b1, (i % N) == 0, (i == 0) ? first_in : WDTH'($urandom), 1'b1);
        drain(400, 1'b0);
        check("sync_first", first_out, first_in);
        check("sync_count", accepted, BLK);

        // in_first at ch 3 mid-block, then a full frame from that sample.
        accepted = 0; m_pushed = 0;
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, $urandom, 1'b1);
        for (int i = 0; i < BLK; i++) step(1'b1, (i % N) == 0, $urandom, 1'b1);
        drain(400, 1'b0);
        check("misalign_err", bus.error, 1'b1);
        check("misalign_count", accepted, BLK);

        // Three blocks while stalled: third is dropped.
        do_reset();
        for (int i = 0; i < 3 * BLK; i++) step(1'b1, (i % N) == 0, $urandom, 1'b0);
        check("overflow_err", bus.error, 1'b1);
        drain(800, 1'b0);
        check("overflow_count", accepted, 2 * BLK);

        // Alternating ready.
        do_reset();
        for (int i = 0; i < 2 * BLK; i++) step(1'b1, (i % N) == 0, $urandom, (i % 2) == 0);
        drain(800, 1'b1);
        check("toggle_count", accepted, 2 * BLK);

        // Random ready over three frames; any drops follow the model.
        do_reset();
        for (int i = 0; i < 3 * BLK; i++)
            step(1'b1, (i % N) == 0, $urandom, $urandom_range(0, 3) != 0);
        drain(1000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "timeout");
    end
endmodule
